shot_arbiter: RTL

Controller that shares the game's single projectile engine between the player's fire button and the enemy's fire request. It arbitrates between the two, sequences the granted shot across the 16-position LED row, and resolves hits against the spaceship position and the enemy target. It keeps the score and the life counters. It sits beside the spaceship LED state block and consumes its ship position as a live input.

---
 rtl/shot_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/shot_arbiter.sv
// shot_arbiter: shares the single projectile engine between player and enemy.
// Round-robin grant, 16-position shot flight, hit/miss resolution, score/lives.
//
// Ports:
//   Clk, rst        clock; synchronous active-low reset
//   req_player      player fire request (level)
//   req_enemy       enemy fire request (level)
//   ship_pos        live spaceship LED position
//   target_pos      live enemy target LED position
//   gnt_player/enemy one-cycle grant pulses
//   shot_active     projectile in flight
//   shot_owner      0 = player, 1 = enemy
//   shot_pos        projectile LED position
//   hit_target      player shot hit the target (pulse)
//   hit_ship        enemy shot hit the ship (pulse)
//   shot_miss       shot left the row (pulse)
//   score           saturating player hit count
//   lives           remaining lives
//   game_over       lives == 0
module shot_arbiter #(
  parameter int STEP_CYCLES = 4,
  parameter int SCORE_W     = 8,
  parameter int LIVES_INIT  = 3
) (
  input  logic               Clk,
  input  logic               rst,
  input  logic               req_player,
  input  logic               req_enemy,
  input  logic [3:0]         ship_pos,
  input  logic [3:0]         target_pos,
  output logic               gnt_player,
  output logic               gnt_enemy,
  output logic               shot_active,
  output logic               shot_owner,
  output logic [3:0]         shot_pos,
  output logic               hit_target,
  output logic               hit_ship,
  output logic               shot_miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST =
    STEP_W'(STEP_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FLY  = 1'b1;

  logic [0:0]        state;
  logic [STEP_W-1:0] step_cnt;
  // 1 = enemy got the last grant; reset value lets the player win the first tie
  logic              last_enemy;

  logic p_ok;
  logic e_ok;
  logic pick_p;
  logic pick_e;
  logic step_edge;
  logic p_hit;
  logic p_miss;
  logic e_hit;
  logic e_miss;

  assign game_over = (lives == 2'd0);

  // A player shot launched from 15 would start off the row
  assign p_ok = req_player && (ship_pos != 4'd15);
  assign e_ok = req_enemy;

  always_comb begin
    pick_p = p_ok && (!e_ok || last_enemy);
    pick_e = e_ok && !pick_p;
  end

  assign step_edge = (state == S_FLY) && (step_cnt == STEP_LAST);

  // Launch position is checked at the first step edge, before any move
  assign p_hit  = !shot_owner && (shot_pos == target_pos);
  assign p_miss = !shot_owner && (shot_pos == 4'd15);
  assign e_hit  =  shot_owner && (shot_pos == ship_pos);
  assign e_miss =  shot_owner && (shot_pos == 4'd0);

  always_ff @(posedge Clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      last_enemy  <= 1'b1;
      shot_active <= 1'b0;
      shot_owner  <= 1'b0;
      shot_pos    <= 4'd0;
      gnt_player  <= 1'b0;
      gnt_enemy   <= 1'b0;
      hit_target  <= 1'b0;
      hit_ship    <= 1'b0;
      shot_miss   <= 1'b0;
      score       <= '0;
      lives       <= 2'(LIVES_INIT);
    end else begin
      gnt_player <= 1'b0;
      gnt_enemy  <= 1'b0;
      hit_target <= 1'b0;
      hit_ship   <= 1'b0;
      shot_miss  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!game_over && (pick_p || pick_e)) begin
            state       <= S_FLY;
            step_cnt    <= '0;
            shot_active <= 1'b1;
            last_enemy  <= pick_e;
            shot_owner  <= pick_e;
            gnt_player  <= pick_p;
            gnt_enemy   <= pick_e;
            shot_pos    <= pick_p ? ship_pos + 4'd1 : 4'd15;
          end
        end
        S_FLY: begin
          if (!step_edge) begin
            step_cnt <= step_cnt + 1'b1;
          end else begin
            step_cnt <= '0;
            if (p_hit) begin
              hit_target <= 1'b1;
              if (score != '1) score <= score + 1'b1;
            end else if (p_miss) begin
              shot_miss <= 1'b1;
            end else if (e_hit) begin
              hit_ship <= 1'b1;
              if (lives != 2'd0) lives <= lives - 2'd1;
            end else if (e_miss) begin
              shot_miss <= 1'b1;
            end else if (shot_owner) begin
              shot_pos <= shot_pos - 4'd1;
            end else begin
              shot_pos <= shot_pos + 4'd1;
            end
            if (p_hit || p_miss || e_hit || e_miss) begin
              state       <= S_IDLE;
              shot_active <= 1'b0;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          shot_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
